// File: rtl/psk_modulator.sv
// DBPSK transmitter: a one-byte holding register feeds a preamble/start/data framer
// that flips the phase of a phase-accumulator square-wave carrier at symbol boundaries.
module psk_modulator #(
    parameter logic [15:0] CW         = 16'h0ff8,
    parameter int          SYM_CYCLES = 4096,
    parameter int          PRE_SYMS   = 8
) (
    input  logic       clk,
    input  logic       rst_in,
    input  logic [3:0] offset,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       ready,
    output logic       sig_out,
    output logic       busy,
    output logic       sym_stb
);

    localparam int CNT_W = (SYM_CYCLES > 1) ? $clog2(SYM_CYCLES) : 1;
    localparam int PRE_W = (PRE_SYMS > 1) ? $clog2(PRE_SYMS) : 1;
    localparam logic [CNT_W-1:0] SYM_LAST = CNT_W'(SYM_CYCLES - 1);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRE_SYMS - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] PRE   = 2'd1;
    localparam logic [1:0] START = 2'd2;
    localparam logic [1:0] DATA  = 2'd3;

    logic [15:0]      acc;
    logic             flip;
    logic [CNT_W-1:0] sym_cnt;
    logic             boundary;
    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [PRE_W-1:0] pre_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       hold;
    logic             hold_full;
    logic [7:0]       shreg;
    logic             sym_bit;
    logic             load_shreg;

    assign boundary = (sym_cnt == SYM_LAST);
    assign sym_stb  = boundary;
    assign busy     = (state != IDLE);
    assign ready    = ~hold_full;

    // The accumulator is only ever cleared by reset, so offset changes keep phase continuity.
    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            acc     <= '0;
            sig_out <= 1'b0;
            sym_cnt <= '0;
        end else begin
            acc     <= acc + CW + {12'd0, offset};
            sig_out <= acc[15] ^ flip;
            sym_cnt <= boundary ? '0 : sym_cnt + CNT_W'(1);
        end
    end

    // sym_bit is the bit of the symbol that begins after the current boundary.
    always_comb begin
        state_nxt  = state;
        sym_bit    = 1'b0;
        load_shreg = 1'b0;
        case (state)
            IDLE: begin
                if (hold_full) begin
                    state_nxt = PRE;
                    sym_bit   = 1'b1;
                end
            end
            PRE: begin
                if (pre_cnt == PRE_LAST) begin
                    state_nxt  = START;
                    load_shreg = 1'b1;
                end else begin
                    sym_bit = 1'b1;
                end
            end
            START: begin
                state_nxt = DATA;
                sym_bit   = shreg[0];
            end
            default: begin
                if (bit_idx == 3'd7) begin
                    if (hold_full) begin
                        state_nxt  = START;
                        load_shreg = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    sym_bit = shreg[bit_idx + 3'd1];
                end
            end
        endcase
    end

    // START entry empties the holding register; a transfer cannot coincide since ready is low then.
    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            state     <= IDLE;
            flip      <= 1'b0;
            pre_cnt   <= '0;
            bit_idx   <= '0;
            hold      <= '0;
            hold_full <= 1'b0;
            shreg     <= '0;
        end else begin
            if (valid && ready) begin
                hold      <= data;
                hold_full <= 1'b1;
            end
            if (boundary) begin
                state <= state_nxt;
                flip  <= flip ^ sym_bit;
                if (state == IDLE) begin
                    pre_cnt <= '0;
                end else if (state == PRE) begin
                    pre_cnt <= pre_cnt + PRE_W'(1);
                end
                if (state == DATA && bit_idx != 3'd7) begin
                    bit_idx <= bit_idx + 3'd1;
                end
                if (load_shreg) begin
                    shreg     <= hold;
                    hold_full <= 1'b0;
                    bit_idx   <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_psk_modulator.sv
// Directed bench for psk_modulator: recovers per-symbol phase from sig_out against a local
// NCO model and compares the resulting bit/busy streams with hand-computed frames.
module tb_psk_modulator;

    localparam int SYM  = 16;
    localparam int NSYM = 512;

    logic       clk = 1'b0;
    logic       rst_in = 1'b0;
    logic [3:0] offset = 4'd0;
    logic [7:0] data = 8'd0;
    logic       valid = 1'b0;
    logic       ready;
    logic       sig_out;
    logic       busy;
    logic       sym_stb;

    psk_modulator #(
        .CW(16'h1000),
        .SYM_CYCLES(SYM),
        .PRE_SYMS(4)
    ) dut (
        .clk(clk),
        .rst_in(rst_in),
        .offset(offset),
        .data(data),
        .valid(valid),
        .ready(ready),
        .sig_out(sig_out),
        .busy(busy),
        .sym_stb(sym_stb)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          edge_n = 0;
    logic [15:0] model_acc = '0;
    logic [15:0] acc_d = '0;
    logic        phase_log [NSYM];
    logic        busy_log [NSYM];
    int          glitch_cnt = 0;
    int          stb_err = 0;
    logic        mon_ph;
    int          mon_s;

    typedef struct {
        logic [7:0] d;
        int         flips;
    } vec_t;
    vec_t vecs [5];

    // Reference carrier: edges since reset release and the accumulator one edge behind.
    always @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            edge_n    <= 0;
            model_acc <= '0;
            acc_d     <= '0;
        end else begin
            edge_n    <= edge_n + 1;
            acc_d     <= model_acc;
            model_acc <= model_acc + 16'h1000 + {12'd0, offset};
        end
    end

    // Phase seen on sig_out after edge n is the flip state after edge n-1.
    always @(negedge clk) begin
        if (rst_in && edge_n > 0) begin
            mon_ph = sig_out ^ acc_d[15];
            mon_s  = (edge_n - 1) / SYM;
            if (mon_s < NSYM) begin
                if ((edge_n - 1) % SYM == 0) begin
                    phase_log[mon_s] = mon_ph;
                    busy_log[mon_s]  = busy;
                end else if (mon_ph !== phase_log[mon_s]) begin
                    glitch_cnt++;
                end
            end
            if (sym_stb !== ((edge_n % SYM) == SYM - 1)) stb_err++;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    function automatic logic bit_of(input int s);
        return (s == 0) ? phase_log[0] : (phase_log[s] ^ phase_log[s-1]);
    endfunction

    function automatic logic [7:0] decode(input int first);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = bit_of(first + i);
        return r;
    endfunction

    function automatic int flip_count(input int first, input int len);
        int n = 0;
        for (int i = 0; i < len; i++) n += int'(bit_of(first + i));
        return n;
    endfunction

    task automatic wait_edge(input int target);
        int guard = 0;
        while (edge_n < target && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        if (edge_n != target) begin
            checks++;
            errors++;
            $display("[TB] FAIL wait_edge: actual %0d required %0d", edge_n, target);
        end
    endtask

    task automatic wait_sym(input int s);
        wait_edge(SYM * s + 2);
    endtask

    task automatic applyStimulus(input logic [7:0] d, output int xfer);
        int guard = 0;
        data  = d;
        valid = 1'b1;
        while (!ready && guard < 400) begin
            @(negedge clk);
            guard++;
        end
        if (!ready) begin
            checks++;
            errors++;
            $display("[TB] FAIL send_timeout: actual ready %0b required 1", ready);
        end
        xfer = edge_n + 1;
        @(negedge clk);
        valid = 1'b0;
    endtask

    task automatic expect_frame(input string name, input int first, input bit pre, input logic [7:0] d);
        logic [12:0] act_b, exp_b, act_busy, exp_busy;
        int len = pre ? 13 : 9;
        int st  = pre ? 4 : 0;
        act_b = '0; exp_b = '0; act_busy = '0; exp_busy = '0;
        for (int i = 0; i < len; i++) begin
            if (i < st)       exp_b[i] = 1'b1;
            else if (i == st) exp_b[i] = 1'b0;
            else              exp_b[i] = d[i - st - 1];
            act_b[i]    = bit_of(first + i);
            act_busy[i] = busy_log[first + i];
            exp_busy[i] = 1'b1;
        end
        checkOutput({name, "_bits"}, 32'(act_b), 32'(exp_b));
        checkOutput({name, "_busy"}, 32'(act_busy), 32'(exp_busy));
    endtask

    initial begin
        int x1, x2, m, cnt;

        vecs[0] = '{8'hA5, 8};
        vecs[1] = '{8'h3C, 8};
        vecs[2] = '{8'h01, 5};
        vecs[3] = '{8'h80, 5};
        vecs[4] = '{8'h7E, 10};

        // Reset: valid during reset must not load anything.
        repeat (3) @(negedge clk);
        data  = 8'h5A;
        valid = 1'b1;
        @(negedge clk);
        checkOutput("rst_sig_out", 32'(sig_out), 0);
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_ready", 32'(ready), 1);
        checkOutput("rst_sym_stb", 32'(sym_stb), 0);
        @(negedge clk);
        checkOutput("rst_no_xfer", 32'(ready), 1);
        valid  = 1'b0;
        rst_in = 1'b1;
        wait_edge(14);
        checkOutput("stb_14", 32'(sym_stb), 0);
        wait_edge(15);
        checkOutput("stb_15", 32'(sym_stb), 1);
        wait_edge(16);
        checkOutput("stb_16", 32'(sym_stb), 0);
        wait_edge(31);
        checkOutput("stb_31", 32'(sym_stb), 1);
        wait_edge(47);
        checkOutput("stb_47", 32'(sym_stb), 1);
        wait_sym(3);
        checkOutput("idle_after_reset",
            32'({busy_log[0], busy_log[1], busy_log[2], bit_of(1), bit_of(2), ready}), 32'h1);

        // Single frames from IDLE at varying carrier/symbol phases.
        for (int i = 0; i < 5; i++) begin
            repeat (i * 3 + 1) @(negedge clk);
            applyStimulus(vecs[i].d, x1);
            checkOutput("ready_drop", 32'(ready), 0);
            m = x1 / SYM + 1;
            wait_sym(m + 14);
            expect_frame("single", m, 1'b1, vecs[i].d);
            checkOutput("single_flips", 32'(flip_count(m, 13)), 32'(vecs[i].flips));
            checkOutput("single_decode", 32'(decode(m + 5)), 32'(vecs[i].d));
            checkOutput("single_busy_edges",
                32'({busy_log[m-1], busy_log[m+12], busy_log[m+13]}), 32'b010);
        end

        // Back-to-back with valid held: second byte waits for START entry, no second preamble.
        @(negedge clk);
        applyStimulus(8'h00, x1);
        applyStimulus(8'hFF, x2);
        m = x1 / SYM + 1;
        checkOutput("b2b_accept", 32'(x2), 32'(SYM * (m + 4) + 1));
        wait_sym(m + 23);
        expect_frame("b2b_first", m, 1'b1, 8'h00);
        expect_frame("b2b_second", m + 13, 1'b0, 8'hFF);
        checkOutput("b2b_flips", 32'(flip_count(m, 22)), 12);
        checkOutput("b2b_busy_end", 32'({busy_log[m+21], busy_log[m+22]}), 32'b10);

        // Byte offered on the clock that enters START: refused there, taken next clock.
        applyStimulus(8'h5A, x1);
        m = x1 / SYM + 1;
        wait_edge(SYM * (m + 4) - 1);
        data  = 8'hC3;
        valid = 1'b1;
        checkOutput("start_clk_ready", 32'(ready), 0);
        applyStimulus(8'hC3, x2);
        checkOutput("start_clk_accept", 32'(x2), 32'(SYM * (m + 4) + 1));
        wait_sym(m + 23);
        expect_frame("start_first", m, 1'b1, 8'h5A);
        expect_frame("start_second", m + 13, 1'b0, 8'hC3);
        checkOutput("start_decode", 32'(decode(m + 14)), 32'hC3);

        // Frequency trim mid-frame: flips must still land only on boundaries.
        applyStimulus(8'h96, x1);
        m = x1 / SYM + 1;
        wait_edge(SYM * (m + 6) + 7);
        offset = 4'hF;
        wait_sym(m + 14);
        expect_frame("offset", m, 1'b1, 8'h96);
        checkOutput("offset_glitch", 32'(glitch_cnt), 0);
        wait_sym(m + 34);
        cnt = flip_count(m + 14, 20);
        checkOutput("offset_idle_flips", 32'(cnt), 0);
        checkOutput("offset_idle_glitch", 32'(glitch_cnt), 0);
        offset = 4'd0;

        // Reset during DATA bit 3 with a byte waiting in the holding register.
        applyStimulus(8'hE7, x1);
        m = x1 / SYM + 1;
        wait_edge(SYM * (m + 6) + 3);
        applyStimulus(8'h11, x2);
        checkOutput("hold_in_data", 32'(x2), 32'(SYM * (m + 6) + 4));
        wait_edge(SYM * (m + 8) + 5);
        #2 rst_in = 1'b0;
        #1;
        checkOutput("async_rst_outputs", 32'({sig_out, busy, ready, sym_stb}), 32'b0010);
        @(negedge clk);
        rst_in = 1'b1;
        wait_sym(3);
        checkOutput("rst_hold_discarded",
            32'({busy_log[0], busy_log[1], busy_log[2], bit_of(1), bit_of(2)}), 0);
        applyStimulus(8'h3C, x1);
        m = x1 / SYM + 1;
        wait_sym(m + 14);
        expect_frame("after_rst", m, 1'b1, 8'h3C);
        checkOutput("after_rst_decode", 32'(decode(m + 5)), 32'h3C);
        checkOutput("after_rst_idle", 32'(busy_log[m+13]), 0);

        checkOutput("glitch_total", 32'(glitch_cnt), 0);
        checkOutput("stb_timing", 32'(stb_err), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #600000;
        $display("[TB] FAIL watchdog: actual timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
